noc_traffic_gen: RTL and testbench

//  Clocked, multi-channel successor to the single-channel CSP data source.

---
 rtl/noc_tg_pkg.sv | 33 +++
 rtl/tg_lfsr16.sv | 38 +++
 rtl/noc_traffic_gen.sv | 198 +++++++++++++++++++
 tb/tb_noc_traffic_gen.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/noc_tg_pkg.sv
// rtl/noc_tg_pkg.sv - shared types and constants for the NoC traffic generator
//
// Purpose : payload-mode and channel-state enums, the LFSR tap mask, and the
//           decoder that folds the reserved mode encoding onto CONST.
// Ports   : none (package)
package noc_tg_pkg;

  typedef enum logic [1:0] {
    TG_INCR  = 2'd0,
    TG_LFSR  = 2'd1,
    TG_CONST = 2'd2
  } tg_mode_e;

  typedef enum logic [1:0] {
    TG_IDLE = 2'd0,
    TG_SEND = 2'd1,
    TG_GAP  = 2'd2,
    TG_DONE = 2'd3
  } tg_state_e;

  // Fibonacci taps for x^16+x^14+x^13+x^11+1: state bits 15, 13, 12, 10.
  localparam logic [15:0] TG_LFSR_TAPS = 16'hB400;

  // Encoding 3 is reserved and behaves exactly like CONST.
  function automatic tg_mode_e tg_decode_mode(input logic [1:0] i_mode);
    case (i_mode)
      2'd0:    return TG_INCR;
      2'd1:    return TG_LFSR;
      default: return TG_CONST;
    endcase
  endfunction

endpackage

// File: rtl/tg_lfsr16.sv
// rtl/tg_lfsr16.sv - 16-bit Fibonacci LFSR with seed load and advance enable
//
// Purpose : pseudo-random payload source for one traffic-generator channel.
// Ports   : i_clk   in  1   rising-edge clock
//           i_rst_n in  1   synchronous active-low reset (reloads SEED)
//           i_load  in  1   reload SEED (has priority over i_adv)
//           i_adv   in  1   step the register once
//           o_state out 16  current register contents
module tg_lfsr16
  import noc_tg_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_load,
  input  logic        i_adv,
  output logic [15:0] o_state
);

  logic [15:0] r_state;
  logic        w_feedback;

  assign w_feedback = ^(r_state & TG_LFSR_TAPS);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= SEED;
    end else if (i_load) begin
      r_state <= SEED;
    end else if (i_adv) begin
      r_state <= {r_state[14:0], w_feedback};
    end
  end

  assign o_state = r_state;

endmodule

// File: rtl/noc_traffic_gen.sv
// rtl/noc_traffic_gen.sv - multi-channel valid/ready flit generator for NoC test harness
//
// Purpose : NUM_CH independent flit streams with programmable payload mode,
//           inter-flit gap and flit count; reports per-channel sent counts and
//           whole-run completion.
// Ports   : clk        in  1             rising-edge clock
//           rst_n      in  1             synchronous active-low reset
//           start      in  1             launch a run, latching the config below
//           stop       in  1             graceful abort (wins over start)
//           mode       in  2             0 INCR, 1 LFSR, 2/3 CONST
//           gap        in  GAP_W         idle cycles after each accepted flit
//           num_pkts   in  CNT_W         flits per channel per run, 0 = unlimited
//           const_val  in  WIDTH         CONST-mode payload
//           out_valid  out NUM_CH        per-channel valid
//           out_data   out NUM_CH*WIDTH  channel c at [c*WIDTH +: WIDTH]
//           out_ready  in  NUM_CH        per-channel ready
//           sent_cnt   out NUM_CH*CNT_W  accepted flits this run, per channel
//           done       out 1             every channel has finished its run
module noc_traffic_gen
  import noc_tg_pkg::*;
#(
  parameter int          NUM_CH    = 4,
  parameter int          WIDTH     = 11,
  parameter int          GAP_W     = 8,
  parameter int          CNT_W     = 16,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    stop,
  input  logic [1:0]              mode,
  input  logic [GAP_W-1:0]        gap,
  input  logic [CNT_W-1:0]        num_pkts,
  input  logic [WIDTH-1:0]        const_val,
  output logic [NUM_CH-1:0]       out_valid,
  output logic [NUM_CH*WIDTH-1:0] out_data,
  input  logic [NUM_CH-1:0]       out_ready,
  output logic [NUM_CH*CNT_W-1:0] sent_cnt,
  output logic                    done
);

  logic [NUM_CH-1:0] w_busy;
  logic [NUM_CH-1:0] w_in_done;
  logic              w_launch;
  logic              r_done;

  // A launch is global: every channel restarts together, and only when no
  // channel is still mid-run. stop on the same cycle suppresses it.
  assign w_launch = start && !stop && (w_busy == '0);

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    tg_state_e        r_state;
    tg_state_e        w_state_nxt;
    tg_mode_e         r_mode;
    logic [GAP_W-1:0] r_gap;
    logic [GAP_W-1:0] r_gap_cnt;
    logic [CNT_W-1:0] r_num;
    logic [CNT_W-1:0] r_sent;
    logic [CNT_W-1:0] w_sent_inc;
    logic [WIDTH-1:0] r_const;
    logic [WIDTH-1:0] r_incr;
    logic             r_stop_pend;
    logic             w_xfer;
    logic             w_last;
    logic [15:0]      w_lfsr;
    logic [WIDTH-1:0] w_payload;
    logic             w_unused_lfsr;

    assign w_xfer     = (r_state == TG_SEND) && out_ready[c];
    assign w_sent_inc = r_sent + 1'b1;
    assign w_last     = (r_num != '0) && (w_sent_inc == r_num);

    tg_lfsr16 #(
      .SEED (LFSR_SEED ^ 16'(c))
    ) u_lfsr (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .i_load  (w_launch),
      .i_adv   (w_xfer),
      .o_state (w_lfsr)
    );

    // Only the low WIDTH bits feed the payload; the rest is state only.
    assign w_unused_lfsr = ^w_lfsr;

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        r_state <= TG_IDLE;
      end else begin
        r_state <= w_state_nxt;
      end
    end

    always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
        TG_IDLE, TG_DONE: begin
          if (w_launch) begin
            w_state_nxt = TG_SEND;
          end
        end
        TG_SEND: begin
          // A stop seen while stalled is remembered; the flit on the wire
          // still completes before the channel goes idle.
          if (w_xfer) begin
            if (r_stop_pend || stop) begin
              w_state_nxt = TG_IDLE;
            end else if (w_last) begin
              w_state_nxt = TG_DONE;
            end else if (r_gap == '0) begin
              w_state_nxt = TG_SEND;
            end else begin
              w_state_nxt = TG_GAP;
            end
          end
        end
        TG_GAP: begin
          if (stop) begin
            w_state_nxt = TG_IDLE;
          end else if (r_gap_cnt <= GAP_W'(1)) begin
            w_state_nxt = TG_SEND;
          end
        end
        default: w_state_nxt = TG_IDLE;
      endcase
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        r_mode      <= TG_INCR;
        r_gap       <= '0;
        r_gap_cnt   <= '0;
        r_num       <= '0;
        r_sent      <= '0;
        r_const     <= '0;
        r_incr      <= '0;
        r_stop_pend <= 1'b0;
      end else if (w_launch) begin
        r_mode      <= tg_decode_mode(mode);
        r_gap       <= gap;
        r_num       <= num_pkts;
        r_const     <= const_val;
        r_gap_cnt   <= '0;
        r_sent      <= '0;
        r_incr      <= '0;
        r_stop_pend <= 1'b0;
      end else if (w_xfer) begin
        // Generators step only on an accepted flit, so backpressure never
        // changes the payload sequence.
        r_sent      <= w_sent_inc;
        r_incr      <= r_incr + 1'b1;
        r_gap_cnt   <= r_gap;
        r_stop_pend <= 1'b0;
      end else begin
        if ((r_state == TG_SEND) && stop) begin
          r_stop_pend <= 1'b1;
        end
        if (r_state == TG_GAP) begin
          r_gap_cnt <= r_gap_cnt - 1'b1;
        end
      end
    end

    always_comb begin
      w_payload = r_const;
      case (r_mode)
        TG_INCR: w_payload = r_incr;
        TG_LFSR: w_payload = w_lfsr[WIDTH-1:0];
        default: w_payload = r_const;
      endcase
    end

    assign w_busy[c]    = (r_state == TG_SEND) || (r_state == TG_GAP);
    assign w_in_done[c] = (r_state == TG_DONE);

    // Data is forced to zero whenever valid is low so idle and reset
    // outputs read 0 regardless of the latched mode.
    assign out_valid[c]                = (r_state == TG_SEND);
    assign out_data[c*WIDTH +: WIDTH]  = (r_state == TG_SEND) ? w_payload : '0;
    assign sent_cnt[c*CNT_W +: CNT_W]  = r_sent;
  end

  // done drops immediately on relaunch; otherwise it follows the channel
  // states one cycle late.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_done <= 1'b0;
    end else if (w_launch) begin
      r_done <= 1'b0;
    end else begin
      r_done <= (w_in_done == {NUM_CH{1'b1}});
    end
  end

  assign done = r_done;

endmodule

// File: tb/tb_noc_traffic_gen.sv
// tb/tb_noc_traffic_gen.sv - directed self-checking bench with per-channel scoreboard
module tb_noc_traffic_gen;

  localparam int NCH = 4;
  localparam int W   = 11;
  localparam int GW  = 8;
  localparam int CW  = 16;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            start;
  logic            stop;
  logic [1:0]      mode;
  logic [GW-1:0]   gap;
  logic [CW-1:0]   num_pkts;
  logic [W-1:0]    const_val;
  logic [NCH-1:0]  out_valid;
  logic [NCH*W-1:0] out_data;
  logic [NCH-1:0]  out_ready;
  logic [NCH*CW-1:0] sent_cnt;
  logic            done;

  int n_cmp  = 0;
  int n_fail = 0;
  bit sb_en  = 1'b1;

  logic [W-1:0] exp_q [NCH][$];
  logic [NCH-1:0] hold_pend = '0;
  logic [W-1:0]   hold_data [NCH];

  noc_traffic_gen #(
    .NUM_CH(NCH), .WIDTH(W), .GAP_W(GW), .CNT_W(CW), .LFSR_SEED(16'hACE1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .mode(mode),
    .gap(gap), .num_pkts(num_pkts), .const_val(const_val),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .sent_cnt(sent_cnt), .done(done)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: observed timeout expected summary");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [15:0] lfsr_nx(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  function automatic logic [W-1:0] data_of(input int c);
    return out_data[c*W +: W];
  endfunction

  function automatic logic [CW-1:0] sent_of(input int c);
    return sent_cnt[c*CW +: CW];
  endfunction

  task automatic push_run(input logic [1:0] m, input int num, input logic [W-1:0] cv);
    logic [15:0] s;
    logic [W-1:0] v;
    for (int c = 0; c < NCH; c++) begin
      s = 16'hACE1 ^ 16'(c);
      for (int i = 0; i < num; i++) begin
        case (m)
          2'd0:    v = W'(i);
          2'd1:    begin v = s[W-1:0]; s = lfsr_nx(s); end
          default: v = cv;
        endcase
        exp_q[c].push_back(v);
      end
    end
  endtask

  task automatic launch(input logic [1:0] m, input int g, input int num, input logic [W-1:0] cv);
    mode = m; gap = GW'(g); num_pkts = CW'(num); const_val = cv;
    push_run(m, num, cv);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("launch_valid", 32'(out_valid), 32'hF);
    check("done_after_launch", 32'(done), 0);
  endtask

  task automatic check_drained(input string tag);
    for (int c = 0; c < NCH; c++) check(tag, exp_q[c].size(), 0);
  endtask

  // Flits observed half a cycle before the edge that accepts them.
  always @(negedge clk) begin
    logic [W-1:0] d;
    if (sb_en && rst_n) begin
      for (int c = 0; c < NCH; c++) begin
        d = out_data[c*W +: W];
        if (hold_pend[c]) begin
          check("hold_valid", 32'(out_valid[c]), 1);
          check("hold_data", 32'(d), 32'(hold_data[c]));
        end
        if (out_valid[c] && out_ready[c]) begin
          n_cmp++;
          assert (exp_q[c].size() != 0) else begin
            n_fail++;
            $error("FAIL sb_extra_flit ch%0d: observed 0x%0h expected none", c, d);
          end
          if (exp_q[c].size() != 0) check("sb_data", 32'(d), 32'(exp_q[c].pop_front()));
        end
        hold_pend[c] = out_valid[c] && !out_ready[c];
        hold_data[c] = d;
      end
    end else begin
      hold_pend = '0;
    end
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; mode = 2'd0; gap = '0;
    num_pkts = '0; const_val = '0; out_ready = '1;
    tick(3);
    check("rst_valid", 32'(out_valid), 0);
    check("rst_data", 32'(out_data), 0);
    check("rst_done", 32'(done), 0);
    check("rst_sent", 32'(sent_of(0)), 0);
    rst_n = 1'b1;
    tick();

    // INCR back-to-back, 4 flits
    launch(2'd0, 0, 4, '0);
    for (int i = 0; i < 4; i++) begin
      check("incr_valid", 32'(out_valid), 32'hF);
      check("incr_ch0_data", 32'(data_of(0)), i);
      tick();
    end
    check("incr_valid_end", 32'(out_valid), 0);
    check("incr_done_early", 32'(done), 0);
    check("incr_sent", 32'(sent_of(0)), 4);
    tick();
    check("incr_done", 32'(done), 1);
    check("incr_sent3", 32'(sent_of(3)), 4);
    check_drained("incr_drain");

    // ch1 stalled for 5 cycles
    out_ready = 4'b1101;
    launch(2'd0, 0, 4, '0);
    tick(5);
    check("stall_valid", 32'(out_valid), 32'h2);
    check("stall_ch1_data", 32'(data_of(1)), 0);
    check("stall_ch0_sent", 32'(sent_of(0)), 4);
    check("stall_ch1_sent", 32'(sent_of(1)), 0);
    check("stall_done", 32'(done), 0);
    out_ready = '1;
    tick(5);
    check("stall_done_end", 32'(done), 1);
    check("stall_ch1_sent_end", 32'(sent_of(1)), 4);
    check_drained("stall_drain");

    // CONST with gap 3
    launch(2'd2, 3, 3, 11'h155);
    for (int o = 0; o < 12; o++) begin
      check("gap_valid_pattern", 32'(out_valid[0]), ((o % 4 == 0) && (o <= 8)) ? 1 : 0);
      tick();
    end
    check("gap_done", 32'(done), 1);
    check_drained("const_drain");

    // LFSR, two identical runs launched from DONE
    for (int r = 0; r < 2; r++) begin
      launch(2'd1, 0, 4, '0);
      check("lfsr_ch0_first", 32'(data_of(0)), 32'h4E1);
      check("lfsr_ch1_first", 32'(data_of(1)), 32'h4E0);
      tick();
      check("lfsr_ch0_second", 32'(data_of(0)), 32'(lfsr_nx(16'hACE1) & 16'h07FF));
      tick(4);
      check("lfsr_done", 32'(done), 1);
    end
    check_drained("lfsr_drain");

    // stop while stalled: flit held, one transfer, then idle
    out_ready = '0;
    push_run(2'd0, 1, '0);
    launch(2'd0, 0, 0, '0);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    tick(2);
    check("stop_held_valid", 32'(out_valid), 32'hF);
    out_ready = '1;
    tick();
    check("stop_idle_valid", 32'(out_valid), 0);
    check("stop_sent", 32'(sent_of(2)), 1);
    check("stop_done", 32'(done), 0);
    start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    check("start_stop_no_launch", 32'(out_valid), 0);
    tick();
    check("start_stop_no_launch2", 32'(out_valid), 0);

    // stop during the gap
    push_run(2'd0, 1, '0);
    launch(2'd0, 5, 0, '0);
    tick();
    check("gapstop_in_gap", 32'(out_valid), 0);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    tick(6);
    check("gapstop_valid", 32'(out_valid), 0);
    check("gapstop_sent", 32'(sent_of(1)), 1);
    check_drained("stop_drain");

    // reset in the middle of an unlimited run
    sb_en = 1'b0;
    launch(2'd0, 0, 0, '0);
    tick(3);
    check("unlim_done", 32'(done), 0);
    rst_n = 1'b0;
    tick();
    check("midrst_valid", 32'(out_valid), 0);
    check("midrst_data", 32'(out_data), 0);
    check("midrst_sent", 32'(sent_of(0)), 0);
    check("midrst_done", 32'(done), 0);
    tick(2);
    rst_n = 1'b1;
    for (int c = 0; c < NCH; c++) exp_q[c].delete();
    sb_en = 1'b1;
    launch(2'd1, 0, 2, '0);
    check("midrst_lfsr_first", 32'(data_of(0)), 32'h4E1);
    tick(3);
    check("midrst_lfsr_done", 32'(done), 1);
    check_drained("midrst_drain");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
